number_accumulator: RTL
=======================

Name: number_accumulator

Overview:
- Downstream of the digit-register path: consumes digit strobes (digit_D/digit_EN) and edit commands issued by the controller.
- Builds the operand number as a signed two's-complement value of width N.
- Provides number_Q to the data stack and ALU.
- Append is a 2-cycle multiply-by-10/add sequence; backspace is an iterative divide-by-10.

Parameters:
- N, 32, operand width; matches data-stack width.
- MAX_DIGITS, 10, maximum number of significant decimal digits accepted.
- CNT_W, 4, width of digit_cnt; must hold MAX_DIGITS.

Ports:
- Clock  in  1  system clock, rising edge.
- Reset  in  1  synchronous, active-high reset.
- digit_D  in  4  decimal digit to append; valid 0..9.
- digit_EN  in  1  append strobe, one cycle.
- bksp_EN  in  1  delete last digit, one cycle.
- neg_EN  in  1  toggle sign, one cycle.
- clr_EN  in  1  clear number, one cycle.
- number_Q  out  N  signed value: neg_Q ? -mag : mag.
- neg_Q  out  1  sign flag.
- digit_cnt  out  CNT_W  count of significant digits.
- busy  out  1  sequence in progress.
- done  out  1  one-cycle pulse when an append or backspace completes.
- ovf  out  1  sticky overflow flag.
- err  out  1  one-cycle pulse on a rejected command.

Behaviour:
- Reset, sampled at a rising edge: mag=0, neg_Q=0, digit_cnt=0, ovf=0, busy=0, done=0, err=0, state=IDLE. Reset overrides all other inputs.
- Internal magnitude mag is N-1 bits; MAXMAG = 2^(N-1)-1.
- States:
  - IDLE: accepts commands.
  - MUL: computes prod = mag*8 + mag*2 at width N+3 into a temp register.
  - ADD: computes sum = prod + digit.
  - DIV: iterative division.
- Command priority in one cycle: clr > bksp > neg > digit. Only the winner is acted on; losers are dropped silently.
- clr_EN is accepted in any state and aborts any sequence. Next cycle: mag=0, neg_Q=0, digit_cnt=0, ovf=0, state=IDLE, no done pulse.
- neg_EN, IDLE only: neg_Q toggles at the next edge. number_Q reflects the change in that same cycle. No busy, no done.
- digit_EN, IDLE only:
  - digit_D > 9: err pulse, no state change.
  - Leading zero (digit 0 while digit_cnt==0): no change, done pulses next cycle.
  - Otherwise: edge t accepts, busy=1 after edge t, MUL at edge t+1, ADD at edge t+2.
  - At edge t+2, if digit_cnt==MAX_DIGITS or sum > MAXMAG: mag unchanged, ovf<=1. Else mag<=sum and digit_cnt increments.
  - Edge t+2 also sets busy<=0 and done<=1 for one cycle.
- bksp_EN, IDLE only:
  - digit_cnt==0: err pulse.
  - Otherwise: restoring division of mag by 10, one quotient bit per cycle, N-1 cycles in DIV.
  - Accepted at edge t: mag<=quotient, digit_cnt decrements, done=1 after edge t+N-1.
  - busy=1 from after edge t until after edge t+N-1.
  - Remainder is discarded. ovf is unaffected.
- Any digit/bksp/neg command while busy=1: err pulse, command dropped.
- number_Q, neg_Q and digit_cnt are registered and stable while busy; mag updates only at sequence end.
- Negation always fits because mag <= MAXMAG. A zero magnitude with neg_Q=1 outputs 0.

Decomposition:
- CONT_INTERNAL.v holds the state encodings (NA_IDLE, NA_MUL, NA_ADD, NA_DIV), 2 bits, and the default MAX_DIGITS.
- One sub-module, div10_seq: start/busy/done handshake, N-1 bit dividend, quotient out, N-1 cycle latency, abort input driven by clr_EN.
- The multiply-by-10 stays inline as shift-add.

Test Plan (N=32, MAX_DIGITS=10):
- Reset asserted with random inputs -> number_Q=0, neg_Q=0, digit_cnt=0, busy/done/ovf/err=0.
- digit_EN with 1, 2, 3, spaced 4 cycles -> busy for 2 cycles each, done 2 cycles after each strobe; final number_Q=123, digit_cnt=3.
- From 123: neg_EN -> number_Q=32'hFFFFFF85. neg_EN again -> 123. Then bksp_EN -> busy 31 cycles, number_Q=12, digit_cnt=2.
- Type 214748364, then 7 -> number_Q=2147483647, ovf=0. Then 8 -> ovf=1, number_Q unchanged, digit_cnt=10.
- Type 214748364, then 8 -> ovf=1, number_Q=214748364.
- digit_EN during bksp busy -> err pulse, result unaffected. clr_EN mid-DIV -> next cycle number_Q=0, busy=0, no done pulse.
- digit_D=4'hA with digit_EN -> err pulse, no change.
- Same-cycle clr_EN+digit_EN -> clr wins.
- bksp_EN with digit_cnt=0 -> err pulse.

Source files
------------

// File: rtl/number_accumulator_pkg.sv
// Shared definitions for the number accumulator.
//   na_state_e          : controller state encoding
//   DEFAULT_MAX_DIGITS  : default digit limit for an operand
//   DIV_BASE            : divisor used by the backspace divider
//   digit_valid()       : true for a decimal digit 0..9
package number_accumulator_pkg;

   typedef enum logic [1:0] {
      NA_IDLE = 2'd0,
      NA_MUL  = 2'd1,
      NA_ADD  = 2'd2,
      NA_DIV  = 2'd3
   } na_state_e;

   localparam int         DEFAULT_MAX_DIGITS = 10;
   localparam logic [4:0] DIV_BASE           = 5'd10;

   function automatic logic digit_valid(input logic [3:0] d);
      return d <= 4'd9;
   endfunction

endpackage

// File: rtl/number_accumulator_div10_seq.sv
// Iterative restoring divide-by-10, one quotient bit per clock.
//   clk_sys, rst : clock, synchronous active-high reset
//   start        : load dividend and perform the first step this edge
//   abort        : drop any division in progress
//   dividend     : W-bit unsigned value to divide
//   busy         : division in progress
//   done         : one-cycle pulse, quotient valid
//   quotient     : dividend / 10 (remainder discarded)
// Latency: start at edge t, done visible after edge t+W-1.
module number_accumulator_div10_seq
   import number_accumulator_pkg::*;
#(
   parameter int W = 31
) (
   input  logic         clk_sys,
   input  logic         rst,
   input  logic         start,
   input  logic         abort,
   input  logic [W-1:0] dividend,
   output logic         busy,
   output logic         done,
   output logic [W-1:0] quotient
);

   localparam int CW = $clog2(W + 1);
   localparam logic [3:0] BASE4 = DIV_BASE[3:0];

   logic [W-1:0]  acc_q, acc_d, src;
   logic [3:0]    rem_q, rem_d, rem_src, diff;
   logic [4:0]    trial;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          busy_q, busy_d, done_q, done_d;
   logic          qbit;

   always_comb begin
      // on start the first step works straight from the dividend input
      src     = start ? dividend : acc_q;
      rem_src = start ? 4'd0 : rem_q;
      trial   = {rem_src, src[W-1]};
      qbit    = (trial >= DIV_BASE);
      // remainder is always < 10, so the low nibble of the subtraction is exact
      diff    = trial[3:0] - BASE4;

      acc_d  = acc_q;
      rem_d  = rem_q;
      cnt_d  = cnt_q;
      busy_d = busy_q;
      done_d = 1'b0;

      if (abort) begin
         busy_d = 1'b0;
         cnt_d  = '0;
      end else if (start) begin
         acc_d  = {src[W-2:0], qbit};
         rem_d  = qbit ? diff : trial[3:0];
         cnt_d  = CW'(W - 1);
         busy_d = 1'b1;
      end else if (busy_q) begin
         acc_d = {src[W-2:0], qbit};
         rem_d = qbit ? diff : trial[3:0];
         cnt_d = cnt_q - CW'(1);
         if (cnt_q == CW'(1)) begin
            busy_d = 1'b0;
            done_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk_sys) begin
      if (rst) begin
         acc_q  <= '0;
         rem_q  <= '0;
         cnt_q  <= '0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
      end else begin
         acc_q  <= acc_d;
         rem_q  <= rem_d;
         cnt_q  <= cnt_d;
         busy_q <= busy_d;
         done_q <= done_d;
      end
   end

   assign busy     = busy_q;
   assign done     = done_q;
   assign quotient = acc_q;

endmodule

// File: rtl/number_accumulator.sv
// Builds a signed decimal operand from digit strobes and edit commands.
//   clk_sys, rst        : clock, synchronous active-high reset
//   digit_D / digit_EN  : append a decimal digit
//   bksp_EN             : delete last digit (divide by 10)
//   neg_EN              : toggle sign
//   clr_EN              : clear, aborts any sequence
//   number_Q            : neg_Q ? -mag : mag
//   neg_Q, digit_cnt    : sign flag, significant digit count
//   busy, done, ovf, err: sequence active, completion pulse,
//                         sticky overflow, rejected-command pulse
//
// state   | meaning
// --------+-----------------------------------------------
// NA_IDLE | accepting commands
// NA_MUL  | prod <= mag*8 + mag*2
// NA_ADD  | sum = prod + digit, commit or flag overflow
// NA_DIV  | waiting on the divide-by-10 sequencer
module number_accumulator
   import number_accumulator_pkg::*;
#(
   parameter int N          = 32,
   parameter int MAX_DIGITS = DEFAULT_MAX_DIGITS,
   parameter int CNT_W      = 4
) (
   input  logic             clk_sys,
   input  logic             rst,
   input  logic [3:0]       digit_D,
   input  logic             digit_EN,
   input  logic             bksp_EN,
   input  logic             neg_EN,
   input  logic             clr_EN,
   output logic [N-1:0]     number_Q,
   output logic             neg_Q,
   output logic [CNT_W-1:0] digit_cnt,
   output logic             busy,
   output logic             done,
   output logic             ovf,
   output logic             err
);

   localparam int MW = N - 1;
   localparam int PW = N + 3;
   localparam logic [PW-1:0] MAXMAG = {4'b0, {MW{1'b1}}};

   na_state_e        state_q, state_d;
   logic [MW-1:0]    mag_q, mag_d;
   logic [PW-1:0]    prod_q, prod_d, sum_w;
   logic [3:0]       dig_q, dig_d;
   logic             neg_q, neg_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             ovf_q, ovf_d, done_q, done_d, err_q, err_d;
   logic             cmd_any;
   logic             div_start, div_busy, div_done;
   logic [MW-1:0]    div_quot;
   logic [N-1:0]     mag_ext;

   always_comb begin
      state_d   = state_q;
      mag_d     = mag_q;
      prod_d    = prod_q;
      dig_d     = dig_q;
      neg_d     = neg_q;
      cnt_d     = cnt_q;
      ovf_d     = ovf_q;
      done_d    = 1'b0;
      err_d     = 1'b0;
      div_start = 1'b0;
      cmd_any   = bksp_EN | neg_EN | digit_EN;
      sum_w     = prod_q + PW'(dig_q);

      if (clr_EN) begin
         mag_d   = '0;
         neg_d   = 1'b0;
         cnt_d   = '0;
         ovf_d   = 1'b0;
         state_d = NA_IDLE;
      end else begin
         case (state_q)
            NA_IDLE: begin
               if (bksp_EN) begin
                  if (cnt_q == '0) begin
                     err_d = 1'b1;
                  end else begin
                     div_start = 1'b1;
                     state_d   = NA_DIV;
                  end
               end else if (neg_EN) begin
                  neg_d = ~neg_q;
               end else if (digit_EN) begin
                  if (!digit_valid(digit_D)) begin
                     err_d = 1'b1;
                  end else if (digit_D == 4'd0 && cnt_q == '0) begin
                     done_d = 1'b1;
                  end else begin
                     dig_d   = digit_D;
                     state_d = NA_MUL;
                  end
               end
            end
            NA_MUL: begin
               prod_d  = (PW'(mag_q) << 3) + (PW'(mag_q) << 1);
               err_d   = cmd_any;
               state_d = NA_ADD;
            end
            NA_ADD: begin
               err_d = cmd_any;
               if (cnt_q == CNT_W'(MAX_DIGITS) || sum_w > MAXMAG) begin
                  ovf_d = 1'b1;
               end else begin
                  mag_d = sum_w[MW-1:0];
                  cnt_d = cnt_q + CNT_W'(1);
               end
               done_d  = 1'b1;
               state_d = NA_IDLE;
            end
            NA_DIV: begin
               err_d = cmd_any;
               if (div_done) begin
                  mag_d   = div_quot;
                  cnt_d   = cnt_q - CNT_W'(1);
                  done_d  = 1'b1;
                  state_d = NA_IDLE;
               end
            end
            default: state_d = NA_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_sys) begin
      if (rst) begin
         state_q <= NA_IDLE;
         mag_q   <= '0;
         prod_q  <= '0;
         dig_q   <= '0;
         neg_q   <= 1'b0;
         cnt_q   <= '0;
         ovf_q   <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         mag_q   <= mag_d;
         prod_q  <= prod_d;
         dig_q   <= dig_d;
         neg_q   <= neg_d;
         cnt_q   <= cnt_d;
         ovf_q   <= ovf_d;
         done_q  <= done_d;
         err_q   <= err_d;
      end
   end

   number_accumulator_div10_seq #(.W(MW)) u_div10 (
      .clk_sys  (clk_sys),
      .rst      (rst),
      .start    (div_start),
      .abort    (clr_EN),
      .dividend (mag_q),
      .busy     (div_busy),
      .done     (div_done),
      .quotient (div_quot)
   );

   // mag never exceeds 2^(N-1)-1, so the negation always fits; -0 is 0
   assign mag_ext   = {1'b0, mag_q};
   assign number_Q  = neg_q ? -mag_ext : mag_ext;
   assign neg_Q     = neg_q;
   assign digit_cnt = cnt_q;
   assign busy      = (state_q != NA_IDLE) | div_busy;
   assign done      = done_q;
   assign ovf       = ovf_q;
   assign err       = err_q;

endmodule
